fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter_if.sv | 24 ++
 rtl/fifo_wr_arbiter.sv | 70 +++++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester and FIFO-write bundle shared by the arbiter and its users
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
);
  localparam int IW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          wr_en;
  logic [DATA_WIDTH-1:0]         data_in;
  logic [IW-1:0]                 grant_id;
  logic                          busy;
  logic [15:0]                   wr_count;
  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, wr_en, data_in, grant_id, busy, wr_count
  );
  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, wr_en, data_in, grant_id, busy, wr_count
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter merging NUM_REQ write requesters into one FIFO write port
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input logic              clk,
  input logic              rst_n,
  fifo_wr_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, BURST} state_t;
  state_t          state, state_n;
  logic [IW-1:0]   rr_ptr, ptr_n, grant, grant_n, pick, idx;
  logic [CW-1:0]   beat_cnt, cnt_n;
  logic [15:0]     wr_count;
  logic            open, beat;
  // lowest circular offset from rr_ptr wins, so scan offsets from high to low
  always_comb begin
    pick = rr_ptr;
    idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = rr_ptr + IW'(k);
      if (bus.req_valid[idx]) pick = idx;
    end
  end
  assign open          = rst_n && state == BURST && !bus.fifo_full;
  assign beat          = open && bus.req_valid[grant];
  assign bus.req_ready = open ? NUM_REQ'(1) << grant : '0;
  assign bus.wr_en     = beat;
  assign bus.data_in   = bus.req_data[grant*DATA_WIDTH +: DATA_WIDTH];
  assign bus.grant_id  = grant;
  assign bus.busy      = state == BURST;
  assign bus.wr_count  = wr_count;
  always_comb begin
    state_n = state;
    grant_n = grant;
    ptr_n   = rr_ptr;
    cnt_n   = beat_cnt;
    if (state == IDLE) begin
      if (|bus.req_valid) begin
        state_n = BURST;
        grant_n = pick;
        cnt_n   = '0;
      end
    end else begin
      cnt_n = beat ? beat_cnt + CW'(1) : beat_cnt;
      if (!bus.req_valid[grant] || (beat && beat_cnt == CW'(MAX_BURST - 1))) begin
        state_n = IDLE;
        ptr_n   = grant + IW'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      beat_cnt <= '0;
      wr_count <= '0;
    end else begin
      state    <= state_n;
      rr_ptr   <= ptr_n;
      grant    <= grant_n;
      beat_cnt <= cnt_n;
      wr_count <= (beat && wr_count != 16'hFFFF) ? wr_count + 16'd1 : wr_count;
    end
  end
endmodule
